// File: rtl/tq_dct4_pkg.sv
// Shared constants and types for the 4-point HEVC forward DCT stage.
// Internal widths are fixed for input samples up to 19 bits.
package tq_dct4_pkg;

   localparam int C64 = 64;
   localparam int C83 = 83;
   localparam int C36 = 36;

   localparam int MUL_IN_W  = 20;
   localparam int MUL_OUT_W = 27;
   localparam int ACC_W     = 28;

   // Scaling by 64 is done as a left shift of the even terms.
   localparam int EVEN_SHL  = $clog2(C64);

   typedef logic signed [MUL_IN_W-1:0]  mul_in_t;
   typedef logic signed [MUL_OUT_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]     acc_t;

   // One row or column of four samples, sign-extended to the butterfly width.
   typedef mul_in_t samp4_t [4];

endpackage

// File: rtl/dct4_odd_mul.sv
// Constant multiplier for the odd butterfly terms: x*36 and x*83,
// built from shifts and adds only.
module dct4_odd_mul
   import tq_dct4_pkg::*;
(
   input  mul_in_t x_i,
   output prod_t   p36_o,
   output prod_t   p83_o
);

   prod_t x_ext;
   prod_t x9;
   prod_t x65;

   assign x_ext = prod_t'(x_i);

   // 9x = x + 8x, 65x = x + 64x, 83x = 65x + 18x, 36x = 9x * 4
   assign x9    = x_ext + (x_ext <<< 3);
   assign x65   = x_ext + (x_ext <<< 6);
   assign p83_o = x65 + (x9 <<< 1);
   assign p36_o = x9 <<< 2;

endmodule

// File: rtl/dct4_1d_pipe.sv
// Three-stage pipelined 1-D 4-point forward DCT with valid/ready on both sides.
// Define DCT4_SATURATE_EN to clip results to OUT_W; otherwise they wrap.
module dct4_1d_pipe
   import tq_dct4_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16,
   parameter int SHIFT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic signed [IN_W-1:0]  i_data_0,
   input  logic signed [IN_W-1:0]  i_data_1,
   input  logic signed [IN_W-1:0]  i_data_2,
   input  logic signed [IN_W-1:0]  i_data_3,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic signed [OUT_W-1:0] o_data_0,
   output logic signed [OUT_W-1:0] o_data_1,
   output logic signed [OUT_W-1:0] o_data_2,
   output logic signed [OUT_W-1:0] o_data_3
);

   // A beat is transferred on either side when its valid and ready are both
   // high at a rising edge; the whole pipe advances together on en.
   localparam acc_t RND = acc_t'(1) <<< (SHIFT - 1);

`ifdef DCT4_SATURATE_EN
   localparam acc_t SAT_MAX = acc_t'({1'b0, {(OUT_W-1){1'b1}}});
   localparam acc_t SAT_MIN = ~SAT_MAX;
`endif

   function automatic logic signed [OUT_W-1:0] reduce(input acc_t v);
`ifdef DCT4_SATURATE_EN
      if (v > SAT_MAX) begin
         return SAT_MAX[OUT_W-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[OUT_W-1:0];
      end
      return v[OUT_W-1:0];
`else
      return v[OUT_W-1:0];
`endif
   endfunction

   logic en;

   logic v1_q, v2_q, v3_q;

   samp4_t  x;
   mul_in_t e0_d, e1_d, o0_d, o1_d;
   mul_in_t e0_q, e1_q, o0_q, o1_q;

   prod_t a0_d, a1_d;
   prod_t a0_q, a1_q;
   prod_t p83a_d, p36a_d, p83b_d, p36b_d;
   prod_t p83a_q, p36a_q, p83b_q, p36b_q;

   acc_t                    y_sum [4];
   logic signed [OUT_W-1:0] y_d   [4];
   logic signed [OUT_W-1:0] y_q   [4];

   assign en      = ~v3_q | i_ready;
   assign o_ready = en;
   assign o_valid = v3_q;

   assign x[0] = mul_in_t'(i_data_0);
   assign x[1] = mul_in_t'(i_data_1);
   assign x[2] = mul_in_t'(i_data_2);
   assign x[3] = mul_in_t'(i_data_3);

   always_comb begin
      e0_d = x[0] + x[3];
      e1_d = x[1] + x[2];
      o0_d = x[0] - x[3];
      o1_d = x[1] - x[2];
   end

   always_comb begin
      a0_d = (prod_t'(e0_q) + prod_t'(e1_q)) <<< EVEN_SHL;
      a1_d = (prod_t'(e0_q) - prod_t'(e1_q)) <<< EVEN_SHL;
   end

   dct4_odd_mul u_mul_o0 (
      .x_i   (o0_q),
      .p36_o (p36a_d),
      .p83_o (p83a_d)
   );

   dct4_odd_mul u_mul_o1 (
      .x_i   (o1_q),
      .p36_o (p36b_d),
      .p83_o (p83b_d)
   );

   always_comb begin
      y_sum[0] = acc_t'(a0_q);
      y_sum[1] = acc_t'(p83a_q) + acc_t'(p36b_q);
      y_sum[2] = acc_t'(a1_q);
      y_sum[3] = acc_t'(p36a_q) - acc_t'(p83b_q);
      for (int k = 0; k < 4; k++) begin
         y_d[k] = reduce((y_sum[k] + RND) >>> SHIFT);
      end
   end

   // Data registers load only behind a valid beat, so o_data stays put across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         e0_q   <= '0;
         e1_q   <= '0;
         o0_q   <= '0;
         o1_q   <= '0;
         a0_q   <= '0;
         a1_q   <= '0;
         p83a_q <= '0;
         p36a_q <= '0;
         p83b_q <= '0;
         p36b_q <= '0;
         for (int k = 0; k < 4; k++) begin
            y_q[k] <= '0;
         end
      end else if (en) begin
         v1_q <= i_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (i_valid) begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            o0_q <= o0_d;
            o1_q <= o1_d;
         end
         if (v1_q) begin
            a0_q   <= a0_d;
            a1_q   <= a1_d;
            p83a_q <= p83a_d;
            p36a_q <= p36a_d;
            p83b_q <= p83b_d;
            p36b_q <= p36b_d;
         end
         if (v2_q) begin
            for (int k = 0; k < 4; k++) begin
               y_q[k] <= y_d[k];
            end
         end
      end
   end

   assign o_data_0 = y_q[0];
   assign o_data_1 = y_q[1];
   assign o_data_2 = y_q[2];
   assign o_data_3 = y_q[3];

endmodule

// File: doc/dct4_1d_pipe.md
Name: dct4_1d_pipe

Overview:
- Pipelined 1-D 4-point HEVC forward DCT stage for the TQ path.
- Accepts one row or column of 4 signed samples per beat.
- Computes the even/odd butterfly, the shift-add products by 64, 83 and 36, and rounding, shift and clip to OUT_W.
- Valid/ready handshake on both sides; feeds the transpose buffer or the quantiser.

Parameters:
IN_W, 16, input sample width; legal 9..19 so butterfly odd terms fit the 20-bit odd multiplier input.
OUT_W, 16, output coefficient width.
SHIFT, 8, right-shift after rounding; legal 1..12 (first pass typically 1, second pass 8).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
i_valid  input  1  upstream beat valid.
o_ready  output  1  block can accept a beat this cycle.
i_data_0..i_data_3  input  IN_W each  signed samples x0..x3.
o_valid  output  1  result beat valid.
i_ready  input  1  downstream accepts result.
o_data_0..o_data_3  output  OUT_W each  signed coefficients y0..y3.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset clears all stage valids, o_valid=0, and o_data_0..3=0.
- Global advance enable: en = ~o_valid | i_ready. o_ready = en, combinational.
- Input accepted when i_valid & o_ready. All stages shift on en; nothing moves when en=0.
- Bubbles are not collapsed under stall.
- Stage 1 (registered), with inputs sign-extended to 20 bits:
  - E0=x0+x3, E1=x1+x2.
  - O0=x0-x3, O1=x1-x2.
- Stage 2 (registered):
  - A0=E0+E1, A1=E0-E1, each shifted left by 6.
  - Odd products: P83a=83*O0, P36a=36*O0, P83b=83*O1, P36b=36*O1.
  - All products are shift-add only; no * operator. 27-bit signed.
- Stage 3 (registered), all 28-bit signed:
  - y0=A0, y2=A1.
  - y1=P83a+P36b, y3=P36a-P83b.
  - Each yk = (yk + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift), then reduced to OUT_W (see Optional Feature).
- Latency: 3 cycles from accept to o_valid when en stays high. Throughput: 1 beat/cycle.
- Stall: while o_valid=1 and i_ready=0:
  - o_data and o_valid hold stable;
  - o_ready=0;
  - internal stages hold.
- Simultaneous output accept and input accept in the same cycle is legal; full throughput is required.
- Reset mid-stream discards all in-flight beats; no partial output after reset release.
- i_data is don't-care when i_valid=0. Stage valids track beats, so garbage never raises o_valid.

Optional Feature:
- Macro DCT4_SATURATE_EN.
- Defined: each shifted result is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: plain truncation to the low OUT_W bits (two's-complement wrap); saves comparators.
- Both builds must pass every test except the overflow scenario, which checks each build's own result.

Decomposition:
- Package tq_dct4_pkg:
  - constants C64=64, C83=83, C36=36;
  - MUL_IN_W=20, MUL_OUT_W=27, ACC_W=28;
  - typedef for the 4-sample signed vector.
- One natural sub-module: dct4_odd_mul. 20-bit signed in, outputs x*36 and x*83 via shift-add (9x=x+8x, 65x=x+64x, 83x=65x+18x, 36x=9x<<2). Instantiated twice (O0, O1).

Test Plan:
- All inputs x=(1,1,1,1), SHIFT=8, i_ready=1 -> after 3 cycles o_valid=1, y=(1,0,0,0).
- x=(100,0,0,-100), SHIFT=8 -> y=(0,65,0,28). Includes 16600+128>>8=65 and 7200+128>>8=28.
- Back-to-back 8 beats with i_ready=1 -> 8 consecutive o_valid cycles, order preserved, o_ready never drops.
- Backpressure: 3 beats in flight, then i_ready=0 for 5 cycles:
  - o_ready=0 and o_data stable throughout;
  - on release, the beats drain in order with no loss or duplication.
- Overflow, SHIFT=1, x=(32767,32767,32767,32767):
  - with DCT4_SATURATE_EN, y0=32767;
  - without it, y0=-128 (0xFF80).
  - Then x all -32768 with SHIFT=8 -> y0=-32768 in both builds.
- Assert rst for 1 cycle with 2 beats in flight -> o_valid=0 and o_data=0 immediately (asynchronous), and no output beats after release until new input.
